// File: rtl/mips_pkg.sv
// Shared constants and types for the pipeline control block.
package mips_pkg;

  localparam logic [4:0]  EXC_NONE    = 5'h10;
  localparam logic [4:0]  EXC_ERET    = 5'h11;
  localparam logic [31:0] EXC_VECTOR  = 32'hBFC0_0380;

  localparam int          DIV_TIMEOUT = 40;
  localparam int          WDOG_W      = 6;

  // Stall vector bits: [0] PC, [1] IF, [2] ID, [3] EXE
  localparam logic [3:0]  STALL_NONE    = 4'b0000;
  localparam logic [3:0]  STALL_LOADUSE = 4'b0111;
  localparam logic [3:0]  STALL_ALL     = 4'b1111;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DIV_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

endpackage

// File: rtl/div_watchdog.sv
// Divider watchdog: counts DIV_WAIT cycles and flags the last allowed one.
module div_watchdog
  import mips_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam logic [WDOG_W-1:0] LAST_CNT = WDOG_W'(DIV_TIMEOUT - 1);

  logic [WDOG_W-1:0] r_count;

  // Counter: cleared when a divide starts, advances once per waiting cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expire = i_enable && (r_count == LAST_CNT);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard / exception controller.
//   state       | meaning
//   ST_RUN      | normal issue; resolves exception, divide start, load-use
//   ST_DIV_WAIT | pipeline frozen until divider ready, exception or watchdog
//   ST_FLUSH    | one quiet cycle after a flush; all requests ignored
module pipe_ctrl
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_stallreq,
  input  logic        exe_div_req,
  input  logic        div_ready,
  input  logic [4:0]  mem_exccode,
  input  logic [31:0] mem_pc,
  input  logic        mem_in_delay,
  input  logic [31:0] cp0_epc,
  output logic [3:0]  stall,
  output logic        flush,
  output logic [31:0] flush_target,
  output logic        div_start,
  output logic        div_abort,
  output logic        exc_commit,
  output logic [31:0] exc_epc,
  output logic        exc_bd,
  output logic        div_timeout
);

  state_t     r_state;
  state_t     w_next;
  logic       r_div_timeout;
  logic [3:0] w_stall;
  logic       w_flush;
  logic       w_div_start;
  logic       w_div_abort;
  logic       w_exc_commit;
  logic       w_set_timeout;
  logic       w_exc;
  logic       w_wd_enable;
  logic       w_wd_expire;

  assign w_exc       = ((r_state == ST_RUN) || (r_state == ST_DIV_WAIT)) &&
                       (mem_exccode != EXC_NONE);
  assign w_wd_enable = (r_state == ST_DIV_WAIT);

  div_watchdog u_div_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_div_start),
    .i_enable (w_wd_enable),
    .o_expire (w_wd_expire)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // Sticky watchdog error, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_timeout <= 1'b0;
    end else if (w_set_timeout) begin
      r_div_timeout <= 1'b1;
    end
  end

  // Next state and per-cycle control, priority exception > divide > load-use
  always_comb begin
    w_next        = r_state;
    w_stall       = STALL_NONE;
    w_flush       = 1'b0;
    w_div_start   = 1'b0;
    w_div_abort   = 1'b0;
    w_exc_commit  = 1'b0;
    w_set_timeout = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_exc) begin
          w_flush      = 1'b1;
          w_exc_commit = (mem_exccode != EXC_ERET);
          w_next       = ST_FLUSH;
        end else if (exe_div_req) begin
          w_div_start  = 1'b1;
          w_stall      = STALL_ALL;
          w_next       = ST_DIV_WAIT;
        end else if (id_stallreq) begin
          w_stall      = STALL_LOADUSE;
        end
      end
      ST_DIV_WAIT: begin
        if (w_exc) begin
          w_flush       = 1'b1;
          w_exc_commit  = (mem_exccode != EXC_ERET);
          w_div_abort   = 1'b1;
          w_next        = ST_FLUSH;
        end else if (div_ready) begin
          w_next        = ST_RUN;
        end else if (w_wd_expire) begin
          w_div_abort   = 1'b1;
          w_set_timeout = 1'b1;
          w_next        = ST_RUN;
        end else begin
          w_stall       = STALL_ALL;
        end
      end
      ST_FLUSH: begin
        w_next = ST_RUN;
      end
      default: begin
        w_next = ST_RUN;
      end
    endcase
  end

  // Control pulses are held quiet while reset is asserted
  assign stall        = rst ? STALL_NONE : w_stall;
  assign flush        = w_flush      & ~rst;
  assign div_start    = w_div_start  & ~rst;
  assign div_abort    = w_div_abort  & ~rst;
  assign exc_commit   = w_exc_commit & ~rst;

  assign flush_target = (mem_exccode == EXC_ERET) ? cp0_epc : EXC_VECTOR;
  assign exc_epc      = mem_in_delay ? (mem_pc - 32'd4) : mem_pc;
  assign exc_bd       = mem_in_delay;
  assign div_timeout  = r_div_timeout;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed literal scenarios plus randomized traffic
// checked every cycle against a behavioural model.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        id_stallreq;
  logic        exe_div_req;
  logic        div_ready;
  logic [4:0]  mem_exccode;
  logic [31:0] mem_pc;
  logic        mem_in_delay;
  logic [31:0] cp0_epc;
  logic [3:0]  stall;
  logic        flush;
  logic [31:0] flush_target;
  logic        div_start;
  logic        div_abort;
  logic        exc_commit;
  logic [31:0] exc_epc;
  logic        exc_bd;
  logic        div_timeout;

  int checks = 0;
  int errors = 0;

  pipe_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_stallreq  (id_stallreq),
    .exe_div_req  (exe_div_req),
    .div_ready    (div_ready),
    .mem_exccode  (mem_exccode),
    .mem_pc       (mem_pc),
    .mem_in_delay (mem_in_delay),
    .cp0_epc      (cp0_epc),
    .stall        (stall),
    .flush        (flush),
    .flush_target (flush_target),
    .div_start    (div_start),
    .div_abort    (div_abort),
    .exc_commit   (exc_commit),
    .exc_epc      (exc_epc),
    .exc_bd       (exc_bd),
    .div_timeout  (div_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_flushp : the cycle after a flush is quiet
  // m_busy   : a divide is outstanding; m_waits = waiting cycles already spent
  logic m_flushp;
  logic m_busy;
  int   m_waits;
  logic m_to;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_flushp <= 1'b0;
      m_busy   <= 1'b0;
      m_waits  <= 0;
      m_to     <= 1'b0;
    end else if (m_flushp) begin
      m_flushp <= 1'b0;
    end else if (mem_exccode != 5'h10) begin
      m_flushp <= 1'b1;
      m_busy   <= 1'b0;
    end else if (m_busy) begin
      if (div_ready) begin
        m_busy <= 1'b0;
      end else if (m_waits + 1 == 40) begin
        m_busy <= 1'b0;
        m_to   <= 1'b1;
      end else begin
        m_waits <= m_waits + 1;
      end
    end else if (exe_div_req) begin
      m_busy  <= 1'b1;
      m_waits <= 0;
    end
  end

  // Compare process: every cycle, away from the rising edge
  always @(negedge clk) begin
    logic [3:0]  es;
    logic        ef, eds, eda, ec, exc;
    es = 4'b0000; ef = 1'b0; eds = 1'b0; eda = 1'b0; ec = 1'b0;
    exc = 1'b0;
    if (!rst && !m_flushp) begin
      exc = (mem_exccode != 5'h10);
      if (exc) begin
        ef  = 1'b1;
        ec  = (mem_exccode != 5'h11);
        eda = m_busy;
      end else if (m_busy) begin
        if (!div_ready) begin
          if (m_waits + 1 == 40) eda = 1'b1;
          else                   es  = 4'b1111;
        end
      end else if (exe_div_req) begin
        eds = 1'b1;
        es  = 4'b1111;
      end else if (id_stallreq) begin
        es  = 4'b0111;
      end
    end
    chk("m_stall",       {28'd0, stall},       {28'd0, es});
    chk("m_flush",       {31'd0, flush},       {31'd0, ef});
    chk("m_div_start",   {31'd0, div_start},   {31'd0, eds});
    chk("m_div_abort",   {31'd0, div_abort},   {31'd0, eda});
    chk("m_exc_commit",  {31'd0, exc_commit},  {31'd0, ec});
    chk("m_div_timeout", {31'd0, div_timeout}, {31'd0, m_to});
    if (ef) begin
      chk("m_flush_target", flush_target, (mem_exccode == 5'h11) ? cp0_epc : 32'hBFC0_0380);
    end
    if (ec) begin
      chk("m_exc_epc", exc_epc, mem_pc - (mem_in_delay ? 32'd4 : 32'd0));
      chk("m_exc_bd",  {31'd0, exc_bd}, {31'd0, mem_in_delay});
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_stallreq  = 1'b0;
    exe_div_req  = 1'b0;
    div_ready    = 1'b0;
    mem_exccode  = 5'h10;
    mem_in_delay = 1'b0;
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_stall"}, {28'd0, stall}, 32'd0);
    chk({name, "_flush"}, {31'd0, flush}, 32'd0);
    chk({name, "_dstart"}, {31'd0, div_start}, 32'd0);
    chk({name, "_dabort"}, {31'd0, div_abort}, 32'd0);
    chk({name, "_commit"}, {31'd0, exc_commit}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    mem_pc  = 32'h0;
    cp0_epc = 32'h0;
    // Requests during reset must not reach the outputs
    id_stallreq = 1'b1;
    exe_div_req = 1'b1;
    mem_exccode = 5'h0C;
    #2;
    chk_quiet("rst");
    chk("rst_timeout", {31'd0, div_timeout}, 32'd0);
    cyc();
    idle();
    cyc();
    rst = 1'b0;
    #3;
    chk_quiet("run_idle");

    // Load-use for two cycles
    cyc(); id_stallreq = 1'b1; #3; chk("lu1", {28'd0, stall}, 32'h7);
    cyc();                     #3; chk("lu2", {28'd0, stall}, 32'h7);
    cyc(); id_stallreq = 1'b0; #3; chk("lu_end", {28'd0, stall}, 32'h0);

    // Divide with ready after 5 waiting cycles
    cyc(); exe_div_req = 1'b1; #3;
    chk("div_start", {31'd0, div_start}, 32'd1);
    chk("div_st0", {28'd0, stall}, 32'hF);
    for (int i = 0; i < 5; i++) begin
      cyc(); exe_div_req = 1'b0; #3;
      chk("div_wait_stall", {28'd0, stall}, 32'hF);
      chk("div_wait_start", {31'd0, div_start}, 32'd0);
    end
    cyc(); div_ready = 1'b1; #3;
    chk("div_rdy_stall", {28'd0, stall}, 32'h0);
    chk("div_rdy_abort", {31'd0, div_abort}, 32'd0);
    cyc(); #3;
    chk("div_after_rdy_ignored", {28'd0, stall}, 32'h0);
    div_ready = 1'b0;

    // Delay-slot exception, then FLUSH ignores requests
    cyc(); mem_exccode = 5'h0C; mem_pc = 32'h8000_0104; mem_in_delay = 1'b1; #3;
    chk("dsx_flush", {31'd0, flush}, 32'd1);
    chk("dsx_commit", {31'd0, exc_commit}, 32'd1);
    chk("dsx_epc", exc_epc, 32'h8000_0100);
    chk("dsx_bd", {31'd0, exc_bd}, 32'd1);
    chk("dsx_target", flush_target, 32'hBFC0_0380);
    chk("dsx_stall", {28'd0, stall}, 32'h0);
    cyc(); id_stallreq = 1'b1; #3;
    chk_quiet("flush_cyc");
    cyc(); idle(); #3;

    // ERET
    cyc(); mem_exccode = 5'h11; cp0_epc = 32'h8000_2000; #3;
    chk("eret_flush", {31'd0, flush}, 32'd1);
    chk("eret_target", flush_target, 32'h8000_2000);
    chk("eret_commit", {31'd0, exc_commit}, 32'd0);
    cyc(); idle(); #3;

    // Exception while waiting for divider
    cyc(); exe_div_req = 1'b1;
    cyc(); exe_div_req = 1'b0;
    cyc(); mem_exccode = 5'h04; mem_pc = 32'h0000_1000; #3;
    chk("dwx_flush", {31'd0, flush}, 32'd1);
    chk("dwx_abort", {31'd0, div_abort}, 32'd1);
    chk("dwx_commit", {31'd0, exc_commit}, 32'd1);
    chk("dwx_epc", exc_epc, 32'h0000_1000);
    cyc(); idle();

    // Watchdog: release on the 40th waiting cycle
    cyc(); exe_div_req = 1'b1;
    cyc(); exe_div_req = 1'b0;
    for (int i = 0; i < 39; i++) begin
      #3; chk("wd_stall", {28'd0, stall}, 32'hF);
      cyc();
    end
    #3;
    chk("wd_rel_stall", {28'd0, stall}, 32'h0);
    chk("wd_abort", {31'd0, div_abort}, 32'd1);
    chk("wd_to_before", {31'd0, div_timeout}, 32'd0);
    cyc(); #3;
    chk("wd_to_set", {31'd0, div_timeout}, 32'd1);
    chk("wd_after_stall", {28'd0, stall}, 32'h0);
    cyc(); cyc(); #3;
    chk("wd_to_held", {31'd0, div_timeout}, 32'd1);

    // Simultaneous requests: exception wins
    cyc(); mem_exccode = 5'h08; exe_div_req = 1'b1; id_stallreq = 1'b1; #3;
    chk("sim_flush", {31'd0, flush}, 32'd1);
    chk("sim_start", {31'd0, div_start}, 32'd0);
    chk("sim_stall", {28'd0, stall}, 32'h0);
    cyc(); idle();

    // Reset mid-DIV_WAIT
    cyc(); exe_div_req = 1'b1;
    cyc(); exe_div_req = 1'b0;
    cyc(); rst = 1'b1; #3;
    chk_quiet("rst_dw");
    chk("rst_dw_to", {31'd0, div_timeout}, 32'd0);
    cyc(); rst = 1'b0; div_ready = 1'b1; #3;
    chk("rst_run_stall", {28'd0, stall}, 32'h0);
    cyc(); idle();

    // Randomized traffic checked by the model
    for (int n = 0; n < 4000; n++) begin
      cyc();
      rst          = ($urandom_range(0, 399) == 0);
      id_stallreq  = ($urandom_range(0, 3) == 0);
      exe_div_req  = ($urandom_range(0, 5) == 0);
      div_ready    = ($urandom_range(0, 29) == 0);
      case ($urandom_range(0, 19))
        0:       mem_exccode = 5'h11;
        1:       mem_exccode = 5'($urandom_range(0, 31));
        default: mem_exccode = 5'h10;
      endcase
      mem_pc       = $urandom;
      mem_in_delay = $urandom_range(0, 1) == 1;
      cp0_epc      = $urandom;
    end
    cyc();
    rst = 1'b0;
    idle();
    cyc();
    #6;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have these ports (name direction width meaning):
 clk  in  1  system clock, all state on rising edge
 rst  in  1  asynchronous, active-high reset
 id_stallreq  in  1  load-use hazard detected in ID
 exe_div_req  in  1  divide instruction present in EXE
 div_ready  in  1  divider result valid
 mem_exccode  in  5  exception code of MEM instruction (5'h10 = none, 5'h11 = ERET)
 mem_pc  in  32  PC of MEM instruction
 mem_in_delay  in  1  MEM instruction is in a delay slot
 cp0_epc  in  32  current CP0 EPC
 stall  out  4  stage stall vector: [0] PC, [1] IF, [2] ID, [3] EXE
 flush  out  1  pipeline flush, one-cycle pulse
 flush_target  out  32  PC redirect, valid while flush=1
 div_start  out  1  divider start, one-cycle pulse
 div_abort  out  1  divider cancel, one-cycle pulse
 exc_commit  out  1  CP0 records exception this cycle
 exc_epc  out  32  EPC value for CP0
 exc_bd  out  1  BD bit for CP0
 div_timeout  out  1  sticky divider watchdog error
REQ-002 Stall rule: stall[k]=1 freezes stage k; the register after stage k inserts a bubble when stall[k]=1 and stall[k+1]=0 (stall[3]=1 always bubbles into MEM).

Function
REQ-003 FSM states SHALL be RUN, DIV_WAIT, FLUSH; single registered state, all outputs combinational from state and inputs except div_timeout and the watchdog counter.
REQ-004 Priority in every state: exception > divide > load-use.
REQ-005 Exception = mem_exccode != 5'h10 while state is RUN or DIV_WAIT: same cycle flush=1, stall=4'b0000, exc_commit=1 unless code is 5'h11; next state FLUSH.
REQ-006 flush_target SHALL be cp0_epc for code 5'h11, else EXC_VECTOR (32'hBFC00380).
REQ-007 exc_epc SHALL be mem_pc-4 when mem_in_delay=1, else mem_pc (modulo 2^32); exc_bd = mem_in_delay.
REQ-008 FLUSH lasts exactly one cycle: stall=0, flush=0, exception/div/stall inputs ignored; next state RUN.
REQ-009 RUN with exe_div_req=1 and no exception: div_start=1, stall=4'b1111, counter cleared, next state DIV_WAIT.
REQ-010 DIV_WAIT: stall=4'b1111 while div_ready=0; div_ready=1 gives stall=0 that cycle and next state RUN; div_ready outside DIV_WAIT is ignored.
REQ-011 Watchdog: 6-bit counter increments each DIV_WAIT cycle; at count DIV_TIMEOUT-1 (39) with div_ready=0: stall=0, div_abort=1, div_timeout set, next state RUN.
REQ-012 Exception in DIV_WAIT: flush per REQ-005 plus div_abort=1 in the same cycle.
REQ-013 RUN with id_stallreq=1, no exception, no exe_div_req: stall=4'b0111; state stays RUN.
REQ-014 RUN with no requests: all outputs 0 except flush_target/exc_epc (don't-care when not qualified).

Reset
REQ-015 rst=1 SHALL immediately force state RUN, counter 0, div_timeout 0; stall, flush, div_start, div_abort, exc_commit SHALL read 0 while rst=1.
REQ-016 Reset during DIV_WAIT SHALL not assert div_abort; the divider is reset by the same rst.

Structure
REQ-017 Shared package mips_pkg SHALL hold EXC_NONE=5'h10, EXC_ERET=5'h11, EXC_VECTOR, DIV_TIMEOUT=40, stall encodings STALL_NONE/STALL_LOADUSE/STALL_ALL, and the FSM state type.
REQ-018 One sub-module div_watchdog (counter, clear, enable, expire output) SHALL be instantiated; everything else inline.

Verification
REQ-019 Load-use: id_stallreq=1 for 2 cycles in RUN -> stall=4'b0111 both cycles, then 4'b0000.
REQ-020 Divide: exe_div_req=1, div_ready after 5 DIV_WAIT cycles -> div_start 1 cycle, stall=4'b1111 for 6 cycles, 0 on the ready cycle.
REQ-021 Delay-slot exception: mem_exccode=5'h0C, mem_pc=32'h8000_0104, mem_in_delay=1 -> flush=1, exc_commit=1, exc_epc=32'h8000_0100, exc_bd=1, flush_target=32'hBFC00380; next cycle flush=0.
REQ-022 ERET: mem_exccode=5'h11, cp0_epc=32'h8000_2000 -> flush=1, flush_target=32'h8000_2000, exc_commit=0.
REQ-023 Watchdog: div_ready held 0 -> release on 40th DIV_WAIT cycle, div_abort=1, div_timeout=1 and held until rst.
REQ-024 Simultaneous: exception + exe_div_req + id_stallreq in RUN -> flush only, div_start=0, stall=0; rst pulse mid-DIV_WAIT -> all outputs 0, state RUN.
